// File: rtl/pipeline_exe_if.sv
// ID/hazard-unit <-> EXE stage bundle: decoded D-side operands and control in,
// registered E-side values and the fetch redirect out.
interface pipeline_exe_if;
    logic        stallE_i;
    logic        flushE_i;
    logic [31:0] rs1DataD_i;
    logic [31:0] rs2DataD_i;
    logic [31:0] pcD_i;
    logic [31:0] pcPlus4D_i;
    logic [31:0] extendedImmD_i;
    logic [3:0]  aluCtrlD_i;
    logic        aluSrcAD_i;
    logic        aluSrcBD_i;
    logic        branchD_i;
    logic        jumpD_i;
    logic        jalrD_i;
    logic [2:0]  funct3D_i;
    logic [2:0]  dMemTypeD_i;
    logic        regWriteEnD_i;
    logic [4:0]  rdIdxD_i;
    logic [1:0]  resultSrcD_i;
    logic        instrIllegalD_i;
    logic [1:0]  forwardAE_i;
    logic [1:0]  forwardBE_i;
    logic [31:0] resultW_i;
    logic [31:0] aluResultM_i;

    logic [31:0] aluResultE_o;
    logic [31:0] extendedImmE_o;
    logic [31:0] pcPlus4E_o;
    logic [31:0] writeDataE_o;
    logic [2:0]  dMemTypeE_o;
    logic        regWriteEnE_o;
    logic [4:0]  rdIdxE_o;
    logic [1:0]  resultSrcE_o;
    logic        instrIllegalE_o;
    logic        pcSrcE_o;
    logic [31:0] pcTargetE_o;

    modport slave (
        input  stallE_i, flushE_i, rs1DataD_i, rs2DataD_i, pcD_i, pcPlus4D_i,
               extendedImmD_i, aluCtrlD_i, aluSrcAD_i, aluSrcBD_i, branchD_i,
               jumpD_i, jalrD_i, funct3D_i, dMemTypeD_i, regWriteEnD_i, rdIdxD_i,
               resultSrcD_i, instrIllegalD_i, forwardAE_i, forwardBE_i,
               resultW_i, aluResultM_i,
        output aluResultE_o, extendedImmE_o, pcPlus4E_o, writeDataE_o,
               dMemTypeE_o, regWriteEnE_o, rdIdxE_o, resultSrcE_o,
               instrIllegalE_o, pcSrcE_o, pcTargetE_o
    );

    modport master (
        output stallE_i, flushE_i, rs1DataD_i, rs2DataD_i, pcD_i, pcPlus4D_i,
               extendedImmD_i, aluCtrlD_i, aluSrcAD_i, aluSrcBD_i, branchD_i,
               jumpD_i, jalrD_i, funct3D_i, dMemTypeD_i, regWriteEnD_i, rdIdxD_i,
               resultSrcD_i, instrIllegalD_i, forwardAE_i, forwardBE_i,
               resultW_i, aluResultM_i,
        input  aluResultE_o, extendedImmE_o, pcPlus4E_o, writeDataE_o,
               dMemTypeE_o, regWriteEnE_o, rdIdxE_o, resultSrcE_o,
               instrIllegalE_o, pcSrcE_o, pcTargetE_o
    );
endinterface

// File: rtl/pipeline_exe.sv
// EXE stage: operand forwarding, ALU, branch/jump resolution and the E-side
// pipeline register (flush beats stall beats load).
module pipeline_exe (
    input  logic           clk,
    input  logic           resetn,
    pipeline_exe_if.slave  bus
);
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic [31:0] alu_result;
    logic        br_taken;
    logic [31:0] jalr_sum;
    logic [31:0] target_addr;

    logic [31:0] alu_result_d,    alu_result_q;
    logic [31:0] ext_imm_d,       ext_imm_q;
    logic [31:0] pc_plus4_d,      pc_plus4_q;
    logic [31:0] write_data_d,    write_data_q;
    logic [2:0]  dmem_type_d,     dmem_type_q;
    logic        reg_write_en_d,  reg_write_en_q;
    logic [4:0]  rd_idx_d,        rd_idx_q;
    logic [1:0]  result_src_d,    result_src_q;
    logic        instr_illegal_d, instr_illegal_q;

    always_comb begin
        case (bus.forwardAE_i)
            2'b01:   fwd_a = bus.resultW_i;
            2'b10:   fwd_a = bus.aluResultM_i;
            default: fwd_a = bus.rs1DataD_i;
        endcase
        case (bus.forwardBE_i)
            2'b01:   fwd_b = bus.resultW_i;
            2'b10:   fwd_b = bus.aluResultM_i;
            default: fwd_b = bus.rs2DataD_i;
        endcase
    end

    assign src_a = bus.aluSrcAD_i ? bus.pcD_i : fwd_a;
    assign src_b = bus.aluSrcBD_i ? bus.extendedImmD_i : fwd_b;
    assign shamt = src_b[4:0];

    always_comb begin
        case (bus.aluCtrlD_i)
            4'd0:    alu_result = src_a + src_b;
            4'd1:    alu_result = src_a - src_b;
            4'd2:    alu_result = src_a << shamt;
            4'd3:    alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            4'd4:    alu_result = {31'd0, src_a < src_b};
            4'd5:    alu_result = src_a ^ src_b;
            4'd6:    alu_result = src_a >> shamt;
            4'd7:    alu_result = $signed(src_a) >>> shamt;
            4'd8:    alu_result = src_a | src_b;
            4'd9:    alu_result = src_a & src_b;
            default: alu_result = 32'd0;
        endcase
    end

    // Branches compare the forwarded register values, independent of the ALU operand selects.
    always_comb begin
        case (bus.funct3D_i)
            3'b000:  br_taken = (fwd_a == fwd_b);
            3'b001:  br_taken = (fwd_a != fwd_b);
            3'b100:  br_taken = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  br_taken = !($signed(fwd_a) < $signed(fwd_b));
            3'b110:  br_taken = (fwd_a < fwd_b);
            3'b111:  br_taken = !(fwd_a < fwd_b);
            default: br_taken = 1'b0;
        endcase
    end

    assign jalr_sum    = fwd_a + bus.extendedImmD_i;
    assign target_addr = bus.jalrD_i ? {jalr_sum[31:1], 1'b0}
                                     : (bus.pcD_i + bus.extendedImmD_i);

    assign bus.pcSrcE_o    = (bus.jumpD_i | bus.jalrD_i | (bus.branchD_i & br_taken))
                             & ~bus.stallE_i & ~bus.flushE_i;
    assign bus.pcTargetE_o = target_addr;

    always_comb begin
        alu_result_d    = alu_result;
        ext_imm_d       = bus.extendedImmD_i;
        pc_plus4_d      = bus.pcPlus4D_i;
        write_data_d    = fwd_b;
        dmem_type_d     = bus.dMemTypeD_i;
        reg_write_en_d  = bus.regWriteEnD_i;
        rd_idx_d        = bus.rdIdxD_i;
        result_src_d    = bus.resultSrcD_i;
        instr_illegal_d = bus.instrIllegalD_i;
        if (bus.flushE_i) begin
            alu_result_d    = 32'd0;
            ext_imm_d       = 32'd0;
            pc_plus4_d      = 32'd0;
            write_data_d    = 32'd0;
            dmem_type_d     = 3'd0;
            reg_write_en_d  = 1'b0;
            rd_idx_d        = 5'd0;
            result_src_d    = 2'd0;
            instr_illegal_d = 1'b0;
        end else if (bus.stallE_i) begin
            alu_result_d    = alu_result_q;
            ext_imm_d       = ext_imm_q;
            pc_plus4_d      = pc_plus4_q;
            write_data_d    = write_data_q;
            dmem_type_d     = dmem_type_q;
            reg_write_en_d  = reg_write_en_q;
            rd_idx_d        = rd_idx_q;
            result_src_d    = result_src_q;
            instr_illegal_d = instr_illegal_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alu_result_q    <= 32'd0;
            ext_imm_q       <= 32'd0;
            pc_plus4_q      <= 32'd0;
            write_data_q    <= 32'd0;
            dmem_type_q     <= 3'd0;
            reg_write_en_q  <= 1'b0;
            rd_idx_q        <= 5'd0;
            result_src_q    <= 2'd0;
            instr_illegal_q <= 1'b0;
        end else begin
            alu_result_q    <= alu_result_d;
            ext_imm_q       <= ext_imm_d;
            pc_plus4_q      <= pc_plus4_d;
            write_data_q    <= write_data_d;
            dmem_type_q     <= dmem_type_d;
            reg_write_en_q  <= reg_write_en_d;
            rd_idx_q        <= rd_idx_d;
            result_src_q    <= result_src_d;
            instr_illegal_q <= instr_illegal_d;
        end
    end

    assign bus.aluResultE_o    = alu_result_q;
    assign bus.extendedImmE_o  = ext_imm_q;
    assign bus.pcPlus4E_o      = pc_plus4_q;
    assign bus.writeDataE_o    = write_data_q;
    assign bus.dMemTypeE_o     = dmem_type_q;
    assign bus.regWriteEnE_o   = reg_write_en_q;
    assign bus.rdIdxE_o        = rd_idx_q;
    assign bus.resultSrcE_o    = result_src_q;
    assign bus.instrIllegalE_o = instr_illegal_q;
endmodule

// File: tb/tb_pipeline_exe.sv
// Randomized + directed bench for pipeline_exe against an arithmetic reference model.
module tb_pipeline_exe;
    logic clk;
    logic resetn;
    pipeline_exe_if bus();

    pipeline_exe dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [31:0] e_alu, e_imm, e_pc4, e_wd;
    logic [2:0]  e_mt;
    logic        e_rwe;
    logic [4:0]  e_rd;
    logic [1:0]  e_rs;
    logic        e_ill;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return rf;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int     sh;
        longint wide;
        logic [63:0] w64;
        sh = int'(b % 32);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * (32'd1 << sh);
            4'd3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a / (32'd1 << sh);
            4'd7: begin
                wide = longint'(int'(a));
                wide = wide >>> sh;
                w64  = wide;
                return w64[31:0];
            end
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return int'(a) < int'(b);
            3'b101: return int'(a) >= int'(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic zero_model();
        e_alu = 0; e_imm = 0; e_pc4 = 0; e_wd = 0;
        e_mt = 0; e_rwe = 0; e_rd = 0; e_rs = 0; e_ill = 0;
    endtask

    task automatic check_regs();
        check_eq("alu_result",    bus.aluResultE_o,    e_alu);
        check_eq("ext_imm",       bus.extendedImmE_o,  e_imm);
        check_eq("pc_plus4",      bus.pcPlus4E_o,      e_pc4);
        check_eq("write_data",    bus.writeDataE_o,    e_wd);
        check_eq("dmem_type",     32'(bus.dMemTypeE_o),   32'(e_mt));
        check_eq("reg_write_en",  32'(bus.regWriteEnE_o), 32'(e_rwe));
        check_eq("rd_idx",        32'(bus.rdIdxE_o),      32'(e_rd));
        check_eq("result_src",    32'(bus.resultSrcE_o),  32'(e_rs));
        check_eq("instr_illegal", 32'(bus.instrIllegalE_o), 32'(e_ill));
    endtask

    task automatic clear_inputs();
        bus.stallE_i = 0; bus.flushE_i = 0;
        bus.rs1DataD_i = 0; bus.rs2DataD_i = 0; bus.pcD_i = 0; bus.pcPlus4D_i = 0;
        bus.extendedImmD_i = 0; bus.aluCtrlD_i = 0; bus.aluSrcAD_i = 0; bus.aluSrcBD_i = 0;
        bus.branchD_i = 0; bus.jumpD_i = 0; bus.jalrD_i = 0; bus.funct3D_i = 0;
        bus.dMemTypeD_i = 0; bus.regWriteEnD_i = 0; bus.rdIdxD_i = 0; bus.resultSrcD_i = 0;
        bus.instrIllegalD_i = 0; bus.forwardAE_i = 0; bus.forwardBE_i = 0;
        bus.resultW_i = 0; bus.aluResultM_i = 0;
    endtask

    task automatic random_inputs(input bit ctl);
        bus.rs1DataD_i     = $urandom;
        bus.rs2DataD_i     = ($urandom_range(0, 3) == 0) ? bus.rs1DataD_i : $urandom;
        bus.pcD_i          = $urandom & 32'hFFFF_FFFC;
        bus.pcPlus4D_i     = bus.pcD_i + 4;
        bus.extendedImmD_i = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom;
        bus.aluCtrlD_i     = 4'($urandom_range(0, 15));
        bus.aluSrcAD_i     = 1'($urandom);
        bus.aluSrcBD_i     = 1'($urandom);
        bus.branchD_i      = 1'($urandom);
        bus.jumpD_i        = ($urandom_range(0, 5) == 0);
        bus.jalrD_i        = ($urandom_range(0, 5) == 0);
        bus.funct3D_i      = 3'($urandom);
        bus.dMemTypeD_i    = 3'($urandom);
        bus.regWriteEnD_i  = 1'($urandom);
        bus.rdIdxD_i       = 5'($urandom);
        bus.resultSrcD_i   = 2'($urandom);
        bus.instrIllegalD_i = 1'($urandom);
        bus.forwardAE_i    = 2'($urandom);
        bus.forwardBE_i    = 2'($urandom);
        bus.resultW_i      = $urandom;
        bus.aluResultM_i   = $urandom;
        bus.stallE_i       = ctl && ($urandom_range(0, 5) == 0);
        bus.flushE_i       = ctl && ($urandom_range(0, 7) == 0);
    endtask

    // Called just after inputs are driven at a falling edge; returns at the next falling edge.
    task automatic run_cycle();
        logic [31:0] fa, fb, sa, sb, alu, tgt;
        logic        psrc, stl, fls;
        #1;
        fa   = m_fwd(bus.forwardAE_i, bus.rs1DataD_i, bus.resultW_i, bus.aluResultM_i);
        fb   = m_fwd(bus.forwardBE_i, bus.rs2DataD_i, bus.resultW_i, bus.aluResultM_i);
        sa   = bus.aluSrcAD_i ? bus.pcD_i : fa;
        sb   = bus.aluSrcBD_i ? bus.extendedImmD_i : fb;
        alu  = m_alu(bus.aluCtrlD_i, sa, sb);
        tgt  = bus.jalrD_i ? ((fa + bus.extendedImmD_i) & 32'hFFFF_FFFE)
                           : (bus.pcD_i + bus.extendedImmD_i);
        stl  = bus.stallE_i;
        fls  = bus.flushE_i;
        psrc = (bus.jumpD_i || bus.jalrD_i || (bus.branchD_i && m_taken(bus.funct3D_i, fa, fb)))
               && !stl && !fls;
        check_eq("pc_src",    32'(bus.pcSrcE_o), 32'(psrc));
        check_eq("pc_target", bus.pcTargetE_o,   tgt);
        @(posedge clk);
        if (!resetn || fls) begin
            zero_model();
        end else if (!stl) begin
            e_alu = alu; e_imm = bus.extendedImmD_i; e_pc4 = bus.pcPlus4D_i; e_wd = fb;
            e_mt = bus.dMemTypeD_i; e_rwe = bus.regWriteEnD_i; e_rd = bus.rdIdxD_i;
            e_rs = bus.resultSrcD_i; e_ill = bus.instrIllegalD_i;
        end
        #1;
        check_regs();
        $display("txn %0d stall=%0d flush=%0d alu=%h rd=%0d pcsrc=%0d tgt=%h",
                 txn, stl, fls, bus.aluResultE_o, bus.rdIdxE_o, psrc, tgt);
        txn++;
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b1;
        clear_inputs();
        random_inputs(1'b0);
        bus.stallE_i = 1'b1;
        #2 resetn = 1'b0;
        #1;
        zero_model();
        check_regs();
        check_eq("reset_pc_src", 32'(bus.pcSrcE_o), 32'd0);
        @(negedge clk);
        run_cycle();
        run_cycle();
        resetn = 1'b1;
        clear_inputs();

        // SRA / SRL on the same operands
        bus.rs1DataD_i = 32'hFFFF_FFF0; bus.extendedImmD_i = 4; bus.aluSrcBD_i = 1;
        bus.aluCtrlD_i = 7;
        run_cycle();
        check_eq("sra_const", bus.aluResultE_o, 32'hFFFF_FFFF);
        bus.aluCtrlD_i = 6;
        run_cycle();
        check_eq("srl_const", bus.aluResultE_o, 32'h0FFF_FFFF);
        clear_inputs();
        bus.rs1DataD_i = 32'hFFFF_FFFF; bus.rs2DataD_i = 1; bus.aluCtrlD_i = 0;
        run_cycle();
        check_eq("add_wrap", bus.aluResultE_o, 32'h0);
        bus.aluCtrlD_i = 3;
        run_cycle();
        check_eq("slt_const", bus.aluResultE_o, 32'h1);
        bus.aluCtrlD_i = 4;
        run_cycle();
        check_eq("sltu_const", bus.aluResultE_o, 32'h0);

        // Forwarding into operand A
        clear_inputs();
        bus.rs1DataD_i = 5; bus.forwardAE_i = 2'b10; bus.aluResultM_i = 100;
        bus.extendedImmD_i = 3; bus.aluSrcBD_i = 1; bus.resultW_i = 7;
        run_cycle();
        check_eq("fwd_mem", bus.aluResultE_o, 32'd103);
        bus.forwardAE_i = 2'b01;
        run_cycle();
        check_eq("fwd_wb", bus.aluResultE_o, 32'd10);

        // Branch compare signed vs unsigned, then JALR alignment
        clear_inputs();
        bus.rs1DataD_i = 32'hFFFF_FFFF; bus.rs2DataD_i = 1; bus.pcD_i = 32'h100;
        bus.extendedImmD_i = 32'hFFFF_FFF8; bus.branchD_i = 1; bus.funct3D_i = 3'b100;
        #1;
        check_eq("blt_pc_src", 32'(bus.pcSrcE_o), 32'd1);
        check_eq("blt_target", bus.pcTargetE_o, 32'h0000_00F8);
        run_cycle();
        bus.funct3D_i = 3'b110;
        #1;
        check_eq("bltu_pc_src", 32'(bus.pcSrcE_o), 32'd0);
        run_cycle();
        clear_inputs();
        bus.rs1DataD_i = 32'h203; bus.extendedImmD_i = 2; bus.jalrD_i = 1;
        #1;
        check_eq("jalr_target", bus.pcTargetE_o, 32'h204);
        run_cycle();

        // Stall three cycles: outputs frozen on the earlier instruction
        clear_inputs();
        bus.rs1DataD_i = 1; bus.rs2DataD_i = 2; bus.rdIdxD_i = 9; bus.regWriteEnD_i = 1;
        run_cycle();
        bus.rs1DataD_i = 40; bus.jumpD_i = 1; bus.rdIdxD_i = 12; bus.stallE_i = 1;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check_eq("stall_hold_alu", bus.aluResultE_o, 32'd3);
            check_eq("stall_pc_src",   32'(bus.pcSrcE_o), 32'd0);
        end
        bus.stallE_i = 0;
        #1;
        check_eq("release_pc_src", 32'(bus.pcSrcE_o), 32'd1);
        run_cycle();
        check_eq("release_alu", bus.aluResultE_o, 32'd42);

        // Stall and flush together: bubble
        bus.stallE_i = 1; bus.flushE_i = 1; bus.dMemTypeD_i = 3'b010;
        run_cycle();
        check_eq("bubble_rwe", 32'(bus.regWriteEnE_o), 32'd0);
        check_eq("bubble_mt",  32'(bus.dMemTypeE_o),   32'd0);
        check_eq("bubble_alu", bus.aluResultE_o,       32'd0);

        // Control pass-through
        clear_inputs();
        bus.rdIdxD_i = 31; bus.resultSrcD_i = 2; bus.dMemTypeD_i = 3'b010;
        bus.instrIllegalD_i = 1;
        run_cycle();
        check_eq("pass_rd",  32'(bus.rdIdxE_o),        32'd31);
        check_eq("pass_rs",  32'(bus.resultSrcE_o),    32'd2);
        check_eq("pass_mt",  32'(bus.dMemTypeE_o),     32'd2);
        check_eq("pass_ill", 32'(bus.instrIllegalE_o), 32'd1);

        // Asynchronous reset in the middle of a stall
        random_inputs(1'b0);
        bus.stallE_i = 1;
        #2 resetn = 1'b0;
        #1;
        zero_model();
        check_regs();
        run_cycle();
        resetn = 1'b1;
        run_cycle();
        bus.stallE_i = 0;
        run_cycle();

        for (int i = 0; i < 400; i++) begin
            random_inputs(1'b1);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
